// File: rtl/key_pkg.sv
// Shared types and default constants for the manual step generator.
// Consumers: key_step_gen and its bench.
package key_pkg;

    typedef enum logic [1:0] {
        LOCK    = 2'd0,
        IDLE    = 2'd1,
        PRESSED = 2'd2,
        REPEAT  = 2'd3
    } key_step_state_t;

    localparam int KEY_CNT_W         = 26;
    localparam int KEY_LONG_PRESS    = 50_000_000;
    localparam int KEY_REPEAT_PERIOD = 10_000_000;

endpackage

// File: rtl/key_step_gen.sv
// Turns a debounced key level into one-cycle CPU step strobes, with
// auto-repeat after a long press.
// Ports: clk, rst (sync, active-high), key_level (1 = pressed),
//        en (gates step_pulse only), step_pulse, repeating, step_count.
import key_pkg::*;

module key_step_gen #(
    parameter int CNT_W         = KEY_CNT_W,
    parameter int LONG_PRESS    = KEY_LONG_PRESS,
    parameter int REPEAT_PERIOD = KEY_REPEAT_PERIOD
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_level,
    input  logic       en,
    output logic       step_pulse,
    output logic       repeating,
    output logic [7:0] step_count
);

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(LONG_PRESS - 1);
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_PERIOD - 1);

    key_step_state_t  state_q, state_d;
    // Hold counter in PRESSED and repeat counter in REPEAT share this.
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pulse_q, pulse_d;
    logic             rep_q, rep_d;
    logic [7:0]       count_q, count_d;
    logic             issue;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        issue   = 1'b0;
        unique case (state_q)
            LOCK: begin
                if (!key_level) state_d = IDLE;
            end
            IDLE: begin
                if (key_level) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                    issue   = 1'b1;
                end
            end
            PRESSED: begin
                if (!key_level) begin
                    state_d = IDLE;
                end else if (cnt_q == HOLD_LAST) begin
                    state_d = REPEAT;
                    cnt_d   = '0;
                    issue   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            REPEAT: begin
                if (!key_level) begin
                    state_d = IDLE;
                end else if (cnt_q == REP_LAST) begin
                    cnt_d = '0;
                    issue = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = LOCK;
        endcase
        // en masks only the visible strobe; the schedule keeps running.
        pulse_d = issue & en;
        count_d = count_q + 8'(pulse_d);
        rep_d   = (state_d == REPEAT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= LOCK;
            cnt_q   <= '0;
            pulse_q <= 1'b0;
            rep_q   <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
            rep_q   <= rep_d;
            count_q <= count_d;
        end
    end

    assign step_pulse = pulse_q;
    assign repeating  = rep_q;
    assign step_count = count_q;

endmodule

// File: tb/tb_key_step_gen.sv
// Bench for key_step_gen with LONG_PRESS=8, REPEAT_PERIOD=4.
// A press-timeline model is checked every cycle, plus literal pulse edges.
module tb_key_step_gen;

    localparam int LP = 8;
    localparam int RP = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       key_level = 1'b0;
    logic       en = 1'b1;
    logic       step_pulse;
    logic       repeating;
    logic [7:0] step_count;

    key_step_gen #(
        .CNT_W(8),
        .LONG_PRESS(LP),
        .REPEAT_PERIOD(RP)
    ) dut (
        .clk(clk),
        .rst(rst),
        .key_level(key_level),
        .en(en),
        .step_pulse(step_pulse),
        .repeating(repeating),
        .step_count(step_count)
    );

    always #5 clk = ~clk;

    int compared = 0;
    int mismatched = 0;
    bit started = 0;

    // Edge index: 0 on the edge that samples rst, then counts up.
    int ecnt = 0;

    // Model: tracks when the current uninterrupted press began.
    int         mcyc = 0;
    int         mstart = 0;
    bit         mlocked = 1;
    bit         mheld = 0;
    bit         mp = 0;
    bit         mr = 0;
    logic [7:0] mc = 8'd0;

    int log_q[$];
    bit rep_seen = 0;

    task automatic chk(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)",
                     name, act, exp, ecnt);
        end
    endtask

    always @(posedge clk) begin
        int  k;
        bit  issue;
        mcyc++;
        if (rst) ecnt = 0;
        else ecnt++;
        if (rst) begin
            mlocked = 1; mheld = 0; mp = 0; mr = 0; mc = 8'd0;
        end else if (mlocked) begin
            if (!key_level) mlocked = 0;
            mp = 0; mr = 0;
        end else if (key_level) begin
            if (!mheld) begin
                mheld = 1;
                mstart = mcyc;
            end
            k = mcyc - mstart;
            issue = (k == 0) || (k >= LP && ((k - LP) % RP) == 0);
            mr = (k >= LP);
            mp = issue && en;
            mc = mc + 8'(mp);
        end else begin
            mheld = 0; mp = 0; mr = 0;
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("step_pulse", int'(step_pulse), int'(mp));
            chk("repeating", int'(repeating), int'(mr));
            chk("step_count", int'(step_count), int'(mc));
            if (step_pulse === 1'b1) log_q.push_back(ecnt);
            if (repeating === 1'b1) rep_seen = 1;
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        started = 1;
        log_q.delete();
        rep_seen = 0;
    endtask

    // Returns at the negedge before edge n, so inputs set next land on n.
    task automatic wait_until(input int n);
        int guard = 0;
        while (ecnt != n - 1 && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 2000) begin
            compared++;
            mismatched++;
            $display("FAIL wait_edge_%0d: timed out at edge %0d", n, ecnt);
        end
    endtask

    task automatic chk_log(input string name, input int exp[$]);
        chk({name, "_count"}, log_q.size(), exp.size());
        foreach (exp[i]) begin
            if (i < log_q.size()) chk({name, "_edge"}, log_q[i], exp[i]);
        end
    endtask

    initial begin
        int e1[$];
        int e2[$];
        int e3[$];
        int e4[$];
        int e6[$];
        e1 = '{10};
        e2 = '{10, 18, 22, 26};
        e3 = '{20};
        e4 = '{10, 26};
        e6 = '{7};

        // Short press
        key_level = 1'b0; en = 1'b1;
        do_reset();
        chk("reset_count", int'(step_count), 0);
        chk("reset_rep", int'(repeating), 0);
        wait_until(10); key_level = 1'b1;
        wait_until(13); key_level = 1'b0;
        wait_until(20);
        chk_log("short", e1);
        chk("short_total", int'(step_count), 1);
        chk("short_rep_seen", int'(rep_seen), 0);

        // Long press into auto-repeat
        do_reset();
        wait_until(10); key_level = 1'b1;
        wait_until(30); key_level = 1'b0;
        wait_until(36);
        chk_log("long", e2);
        chk("long_total", int'(step_count), 4);
        chk("long_rep_end", int'(repeating), 0);
        chk("long_rep_seen", int'(rep_seen), 1);

        // Key held through reset
        key_level = 1'b1;
        do_reset();
        wait_until(15); key_level = 1'b0;
        wait_until(20); key_level = 1'b1;
        wait_until(22); key_level = 1'b0;
        wait_until(26);
        chk_log("lock", e3);
        chk("lock_total", int'(step_count), 1);

        // Enable gap during repeat
        do_reset();
        wait_until(10); key_level = 1'b1;
        wait_until(17); en = 1'b0;
        wait_until(24); en = 1'b1;
        wait_until(30); key_level = 1'b0;
        wait_until(36);
        chk_log("en_gap", e4);
        chk("en_gap_total", int'(step_count), 2);
        chk("en_gap_rep_seen", int'(rep_seen), 1);

        // 256 short presses wrap the counter
        do_reset();
        repeat (256) begin
            @(negedge clk); key_level = 1'b1;
            @(negedge clk); key_level = 1'b0;
        end
        @(negedge clk);
        @(negedge clk);
        chk("wrap_presses", log_q.size(), 256);
        chk("wrap_total", int'(step_count), 0);

        // Reset during repeat
        do_reset();
        wait_until(10); key_level = 1'b1;
        wait_until(20); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        chk("rst_mid_pulse", int'(step_pulse), 0);
        chk("rst_mid_rep", int'(repeating), 0);
        chk("rst_mid_count", int'(step_count), 0);
        log_q.delete();
        wait_until(5);
        chk("rst_mid_locked", log_q.size(), 0);
        key_level = 1'b0;
        wait_until(7); key_level = 1'b1;
        wait_until(8); key_level = 1'b0;
        wait_until(12);
        chk_log("rst_mid_resume", e6);
        chk("rst_mid_total", int'(step_count), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
